pll_lock_supervisor: RTL and testbench

- Control-side counterpart of the core PLL wrapper; runs on the PLL reference clock (74.25 MHz).
- Drives the PLL's active-high reset input and consumes its asynchronous locked output.
- Releases the core-domain reset only after lock has been continuously stable.
- Re-runs the PLL reset/lock sequence on timeout, lock loss or software request, and keeps saturating event counters for status readout.

---
 rtl/pll_lock_supervisor.sv | 140 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for stable lock,
// releases the core reset and re-runs the sequence on timeout, lock loss or request.
module pll_lock_supervisor #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 8
) (
    input  logic             clk_74a,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             restart_req,
    output logic             pll_rst,
    output logic             core_reset_n,
    output logic             running,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] lock_loss_count
);

    localparam int RW = $clog2(RST_CYCLES);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t        st;
    logic [1:0]    sync_q;
    logic          locked_s;
    logic [RW-1:0] rst_cnt;
    logic [SW-1:0] stable_cnt;
    logic [TW-1:0] tmo_cnt;

    assign locked_s = sync_q[1];
    assign state    = st;

    // pll_locked comes from the PLL's own clock domain; only the synchronized copy is used.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            st              <= RESET_PLL;
            pll_rst         <= 1'b1;
            core_reset_n    <= 1'b0;
            running         <= 1'b0;
            rst_cnt         <= '0;
            stable_cnt      <= '0;
            tmo_cnt         <= '0;
            retry_count     <= '0;
            lock_loss_count <= '0;
        end else if (restart_req) begin
            st           <= RESET_PLL;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            running      <= 1'b0;
            rst_cnt      <= '0;
            stable_cnt   <= '0;
            tmo_cnt      <= '0;
            // A lock drop coinciding with the request is still recorded.
            if (st == RUN && !locked_s && lock_loss_count != '1) begin
                lock_loss_count <= lock_loss_count + 1'b1;
            end
        end else begin
            case (st)
                RESET_PLL: begin
                    if (rst_cnt == RST_LAST) begin
                        st         <= WAIT_LOCK;
                        pll_rst    <= 1'b0;
                        rst_cnt    <= '0;
                        stable_cnt <= '0;
                        tmo_cnt    <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Stable completion is tested first so it wins a tie with the timeout.
                    if (locked_s && stable_cnt == STABLE_LAST) begin
                        st           <= RUN;
                        core_reset_n <= 1'b1;
                        running      <= 1'b1;
                        rst_cnt      <= '0;
                        stable_cnt   <= '0;
                        tmo_cnt      <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        st         <= RESET_PLL;
                        pll_rst    <= 1'b1;
                        rst_cnt    <= '0;
                        stable_cnt <= '0;
                        tmo_cnt    <= '0;
                        if (retry_count != '1) begin
                            retry_count <= retry_count + 1'b1;
                        end
                    end else begin
                        stable_cnt <= locked_s ? stable_cnt + 1'b1 : '0;
                        tmo_cnt    <= tmo_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        st           <= RESET_PLL;
                        pll_rst      <= 1'b1;
                        core_reset_n <= 1'b0;
                        running      <= 1'b0;
                        rst_cnt      <= '0;
                        stable_cnt   <= '0;
                        tmo_cnt      <= '0;
                        if (lock_loss_count != '1) begin
                            lock_loss_count <= lock_loss_count + 1'b1;
                        end
                    end
                end
                default: begin
                    st           <= RESET_PLL;
                    pll_rst      <= 1'b1;
                    core_reset_n <= 1'b0;
                    running      <= 1'b0;
                    rst_cnt      <= '0;
                    stable_cnt   <= '0;
                    tmo_cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table, saturation and async-reset
// sequences, then randomized lock/restart traffic against a cycle-level reference model.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES     = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int CNT_W          = 8;
    localparam int CNT_MAX        = (1 << CNT_W) - 1;

    logic             clk_74a     = 1'b0;
    logic             reset_n     = 1'b0;
    logic             pll_locked  = 1'b0;
    logic             restart_req = 1'b0;
    logic             pll_rst;
    logic             core_reset_n;
    logic             running;
    logic [1:0]       state;
    logic [CNT_W-1:0] retry_count;
    logic [CNT_W-1:0] lock_loss_count;

    always #5 clk_74a = ~clk_74a;

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_74a        (clk_74a),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .restart_req    (restart_req),
        .pll_rst        (pll_rst),
        .core_reset_n   (core_reset_n),
        .running        (running),
        .state          (state),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0/1/2, edges spent in the current mode, run of
    // consecutive synchronized-locked samples, and pll_locked delayed by two edges.
    int m_mode, m_age, m_run, m_retry, m_loss;
    bit lk_q[$];

    function automatic void model_reset();
        m_mode = 0; m_age = 0; m_run = 0; m_retry = 0; m_loss = 0;
        lk_q = {1'b0, 1'b0};
    endfunction

    function automatic void model_enter(input int mode);
        m_mode = mode; m_age = 0; m_run = 0;
    endfunction

    function automatic void model_step(input bit lk, input bit rq);
        bit ls;
        ls = lk_q.pop_front();
        lk_q.push_back(lk);
        if (rq) begin
            if (m_mode == 2 && !ls) m_loss = (m_loss < CNT_MAX) ? m_loss + 1 : CNT_MAX;
            model_enter(0);
        end else if (m_mode == 0) begin
            m_age++;
            if (m_age == RST_CYCLES) model_enter(1);
        end else if (m_mode == 1) begin
            m_age++;
            m_run = ls ? m_run + 1 : 0;
            if (m_run == STABLE_CYCLES) begin
                model_enter(2);
            end else if (m_age == TIMEOUT_CYCLES) begin
                m_retry = (m_retry < CNT_MAX) ? m_retry + 1 : CNT_MAX;
                model_enter(0);
            end
        end else if (!ls) begin
            m_loss = (m_loss < CNT_MAX) ? m_loss + 1 : CNT_MAX;
            model_enter(0);
        end
    endfunction

    always @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step(pll_locked, restart_req);
    end

    task automatic model_cmp(input string tag);
        chk({tag, ".state"},   32'(state),           32'(m_mode));
        chk({tag, ".pll_rst"}, 32'(pll_rst),         32'(m_mode == 0));
        chk({tag, ".core_rn"}, 32'(core_reset_n),    32'(m_mode == 2));
        chk({tag, ".running"}, 32'(running),         32'(m_mode == 2));
        chk({tag, ".retry"},   32'(retry_count),     32'(m_retry));
        chk({tag, ".loss"},    32'(lock_loss_count), 32'(m_loss));
    endtask

    task automatic tick();
        @(posedge clk_74a);
        #1;
    endtask

    typedef struct {
        bit rn;
        bit lk;
        bit rq;
        int n;
        int st;
        bit prst;
        bit core;
        bit run;
        int retry;
        int loss;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rn, input bit lk, input bit rq, input int n, input int st,
                       input bit prst, input bit core, input bit run, input int retry,
                       input int loss);
        vec_t v;
        v.rn = rn; v.lk = lk; v.rq = rq; v.n = n; v.st = st;
        v.prst = prst; v.core = core; v.run = run; v.retry = retry; v.loss = loss;
        tbl.push_back(v);
    endtask

    initial begin
        model_reset();

        // Power-up: sequence to RUN with lock raised right after pll_rst falls.
        add(1, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 9, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 2, 0, 1, 1, 0, 0);
        // Restart from RUN, then a second restart inside RESET_PLL.
        add(1, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 2, 0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 3, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 7, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 2, 0, 1, 1, 0, 0);
        // Lock loss in RUN (third edge), then relock.
        add(1, 0, 0, 2, 2, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 4, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 7, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 1, 2, 0, 1, 1, 0, 1);
        // Lock glitch during WAIT_LOCK.
        add(1, 1, 1, 1, 0, 1, 0, 0, 0, 1);
        add(1, 0, 0, 4, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 5, 1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 9, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 1, 2, 0, 1, 1, 0, 1);
        // Lock loss, then lock held low: two timeouts.
        add(1, 0, 0, 2, 2, 0, 1, 1, 0, 1);
        add(1, 0, 0, 1, 0, 1, 0, 0, 0, 2);
        add(1, 0, 0, 4, 1, 0, 0, 0, 0, 2);
        add(1, 0, 0, 63, 1, 0, 0, 0, 0, 2);
        add(1, 0, 0, 1, 0, 1, 0, 0, 1, 2);
        add(1, 0, 0, 3, 0, 1, 0, 0, 1, 2);
        add(1, 0, 0, 1, 1, 0, 0, 0, 1, 2);
        add(1, 0, 0, 63, 1, 0, 0, 0, 1, 2);
        add(1, 0, 0, 1, 0, 1, 0, 0, 2, 2);

        repeat (3) tick();
        chk("reset.state",   32'(state),           32'd0);
        chk("reset.pll_rst", 32'(pll_rst),         32'd1);
        chk("reset.core_rn", 32'(core_reset_n),    32'd0);
        chk("reset.running", 32'(running),         32'd0);
        chk("reset.retry",   32'(retry_count),     32'd0);
        chk("reset.loss",    32'(lock_loss_count), 32'd0);

        foreach (tbl[i]) begin
            reset_n     = tbl[i].rn;
            pll_locked  = tbl[i].lk;
            restart_req = tbl[i].rq;
            for (int c = 0; c < tbl[i].n; c++) begin
                tick();
                restart_req = 1'b0;
            end
            chk($sformatf("vec%0d.state", i),   32'(state),           32'(tbl[i].st));
            chk($sformatf("vec%0d.pll_rst", i), 32'(pll_rst),         32'(tbl[i].prst));
            chk($sformatf("vec%0d.core_rn", i), 32'(core_reset_n),    32'(tbl[i].core));
            chk($sformatf("vec%0d.running", i), 32'(running),         32'(tbl[i].run));
            chk($sformatf("vec%0d.retry", i),   32'(retry_count),     32'(tbl[i].retry));
            chk($sformatf("vec%0d.loss", i),    32'(lock_loss_count), 32'(tbl[i].loss));
            model_cmp($sformatf("vec%0d.model", i));
        end

        // 298 further timeouts: 300 in total, retry_count must stick at its maximum.
        pll_locked = 1'b0;
        repeat (298 * (RST_CYCLES + TIMEOUT_CYCLES)) tick();
        chk("sat.retry", 32'(retry_count), 32'(CNT_MAX));
        chk("sat.state", 32'(state),       32'd0);
        model_cmp("sat.model");

        // Asynchronous reset in the middle of WAIT_LOCK.
        repeat (RST_CYCLES + 5) tick();
        chk("pre_areset.state", 32'(state),           32'd1);
        chk("pre_areset.loss",  32'(lock_loss_count), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset.state",   32'(state),           32'd0);
        chk("areset.pll_rst", 32'(pll_rst),         32'd1);
        chk("areset.core_rn", 32'(core_reset_n),    32'd0);
        chk("areset.running", 32'(running),         32'd0);
        chk("areset.retry",   32'(retry_count),     32'd0);
        chk("areset.loss",    32'(lock_loss_count), 32'd0);
        model_cmp("areset.model");
        tick();
        reset_n = 1'b1;

        // Randomized lock levels with occasional restart requests.
        for (int seg = 0; seg < 150; seg++) begin
            int hold;
            pll_locked = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                restart_req = ($urandom_range(0, 49) == 0);
                tick();
                model_cmp("rand");
            end
            restart_req = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
